mouse_master_sm: RTL and testbench

PS/2 mouse host-side controller that sequences the byte-level receiver and transmitter. After reset it runs the mouse initialisation handshake (reset command, acknowledge, self-test, device ID, enable streaming, acknowledge), then collects 3-byte movement packets. It presents each packet as status/X/Y registers with a one-cycle interrupt to the downstream position tracker. It sits between the receiver/transmitter pair and the mouse-position logic. It is the only block that drives the receiver's READ_ENABLE and the transmitter's SEND_BYTE.

---
 rtl/mouse_master_sm.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_mouse_master_sm.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_master_sm.sv
// mouse_master_sm
// Host-side PS/2 mouse sequencer. Runs the reset / self-test / ID / enable
// handshake through the byte transmitter and receiver, then assembles
// 3-byte movement packets and hands each complete packet to the position
// tracker with a one-cycle interrupt. A watchdog restarts a stalled
// handshake and abandons a stalled packet.
module mouse_master_sm #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE,
    output logic [3:0] STATE
);

    // Watchdog width: enough bits to hold TIMEOUT_CYCLES-1.
    localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WDOG_ONE  = WDW'(1);

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    typedef enum logic [3:0] {
        ST_INIT          = 4'd0,
        ST_SEND_RST      = 4'd1,
        ST_WAIT_SENT_RST = 4'd2,
        ST_WAIT_ACK1     = 4'd3,
        ST_WAIT_SELFTEST = 4'd4,
        ST_WAIT_ID       = 4'd5,
        ST_SEND_EN       = 4'd6,
        ST_WAIT_SENT_EN  = 4'd7,
        ST_WAIT_ACK2     = 4'd8,
        ST_RX_STATUS     = 4'd9,
        ST_RX_DX         = 4'd10,
        ST_RX_DY         = 4'd11
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [WDW-1:0] wdog_q;
    logic [WDW-1:0] wdog_d;
    logic [7:0]     status_sh_q;
    logic [7:0]     dx_sh_q;
    logic           latch_status_d;
    logic           latch_dx_d;
    logic           commit_d;
    logic           timeout_s;
    logic           byte_clean_s;

    logic           send_byte_q;
    logic [7:0]     byte_to_send_q;
    logic [7:0]     byte_to_send_d;
    logic           read_enable_q;
    logic [7:0]     mouse_status_q;
    logic [7:0]     mouse_dx_q;
    logic [7:0]     mouse_dy_q;
    logic           send_interrupt_q;
    logic           init_done_q;

    // A handshake response is accepted only when framing was clean and the
    // byte equals the one the mouse is required to send at this step.
    function automatic logic rsp_ok(input logic [1:0] err,
                                    input logic [7:0] data,
                                    input logic [7:0] exp_byte);
        return (err == 2'b00) && (data == exp_byte);
    endfunction

    // States in which the watchdog runs (waiting on the mouse or transmitter).
    function automatic logic wdog_runs(input state_t st);
        logic r;
        case (st)
            ST_WAIT_SENT_RST, ST_WAIT_ACK1, ST_WAIT_SELFTEST, ST_WAIT_ID,
            ST_WAIT_SENT_EN, ST_WAIT_ACK2, ST_RX_DX, ST_RX_DY: r = 1'b1;
            default:                                           r = 1'b0;
        endcase
        return r;
    endfunction

    // States in which the receiver must be listening.
    function automatic logic rx_listen(input state_t st);
        logic r;
        case (st)
            ST_WAIT_ACK1, ST_WAIT_SELFTEST, ST_WAIT_ID, ST_WAIT_ACK2,
            ST_RX_STATUS, ST_RX_DX, ST_RX_DY: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    // Streaming states; INIT_DONE follows membership of this set.
    function automatic logic streaming(input state_t st);
        logic r;
        case (st)
            ST_RX_STATUS, ST_RX_DX, ST_RX_DY: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state, packet-capture strobes and watchdog next value.
    always_comb begin
        state_d        = state_q;
        latch_status_d = 1'b0;
        latch_dx_d     = 1'b0;
        commit_d       = 1'b0;
        timeout_s      = (wdog_q == WDOG_LAST);
        byte_clean_s   = (BYTE_ERROR_CODE == 2'b00);

        case (state_q)
            ST_INIT: begin
                state_d = ST_SEND_RST;
            end
            ST_SEND_RST: begin
                state_d = ST_WAIT_SENT_RST;
            end
            ST_WAIT_SENT_RST: begin
                if (BYTE_SENT) begin
                    state_d = ST_WAIT_ACK1;
                end else if (timeout_s) begin
                    state_d = ST_SEND_RST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_ACK1: begin
                if (BYTE_READY) begin
                    state_d = rsp_ok(BYTE_ERROR_CODE, BYTE_READ, RSP_ACK)
                              ? ST_WAIT_SELFTEST : ST_SEND_RST;
                end else if (timeout_s) begin
                    state_d = ST_SEND_RST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_SELFTEST: begin
                if (BYTE_READY) begin
                    state_d = rsp_ok(BYTE_ERROR_CODE, BYTE_READ, RSP_BAT_OK)
                              ? ST_WAIT_ID : ST_SEND_RST;
                end else if (timeout_s) begin
                    state_d = ST_SEND_RST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_ID: begin
                if (BYTE_READY) begin
                    state_d = rsp_ok(BYTE_ERROR_CODE, BYTE_READ, RSP_ID)
                              ? ST_SEND_EN : ST_SEND_RST;
                end else if (timeout_s) begin
                    state_d = ST_SEND_RST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SEND_EN: begin
                state_d = ST_WAIT_SENT_EN;
            end
            ST_WAIT_SENT_EN: begin
                if (BYTE_SENT) begin
                    state_d = ST_WAIT_ACK2;
                end else if (timeout_s) begin
                    state_d = ST_SEND_RST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT_ACK2: begin
                if (BYTE_READY) begin
                    state_d = rsp_ok(BYTE_ERROR_CODE, BYTE_READ, RSP_ACK)
                              ? ST_RX_STATUS : ST_SEND_RST;
                end else if (timeout_s) begin
                    state_d = ST_SEND_RST;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RX_STATUS: begin
                // Bit 3 of a status byte is always 1; anything else is a
                // misaligned byte and is dropped to regain packet framing.
                if (BYTE_READY && byte_clean_s && BYTE_READ[3]) begin
                    state_d        = ST_RX_DX;
                    latch_status_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RX_DX: begin
                if (BYTE_READY) begin
                    if (byte_clean_s) begin
                        state_d    = ST_RX_DY;
                        latch_dx_d = 1'b1;
                    end else begin
                        state_d = ST_RX_STATUS;
                    end
                end else if (timeout_s) begin
                    state_d = ST_RX_STATUS;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RX_DY: begin
                if (BYTE_READY) begin
                    state_d  = ST_RX_STATUS;
                    commit_d = byte_clean_s;
                end else if (timeout_s) begin
                    state_d = ST_RX_STATUS;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Watchdog restarts on every state change and only runs while waiting.
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (wdog_runs(state_q)) begin
            wdog_d = wdog_q + WDOG_ONE;
        end else begin
            wdog_d = '0;
        end

        // Command byte is loaded on entry to a send state and held otherwise.
        if (state_d == ST_SEND_RST) begin
            byte_to_send_d = CMD_RESET;
        end else if (state_d == ST_SEND_EN) begin
            byte_to_send_d = CMD_ENABLE;
        end else begin
            byte_to_send_d = byte_to_send_q;
        end
    end

    // State, watchdog, shadows and all outputs registered from next-state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= ST_INIT;
            wdog_q           <= '0;
            status_sh_q      <= 8'h00;
            dx_sh_q          <= 8'h00;
            send_byte_q      <= 1'b0;
            byte_to_send_q   <= 8'h00;
            read_enable_q    <= 1'b0;
            mouse_status_q   <= 8'h00;
            mouse_dx_q       <= 8'h00;
            mouse_dy_q       <= 8'h00;
            send_interrupt_q <= 1'b0;
            init_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            wdog_q         <= wdog_d;
            byte_to_send_q <= byte_to_send_d;
            send_byte_q    <= (state_d == ST_SEND_RST) || (state_d == ST_SEND_EN);
            read_enable_q  <= rx_listen(state_d);
            init_done_q    <= streaming(state_d);
            send_interrupt_q <= commit_d;
            if (latch_status_d) begin
                status_sh_q <= BYTE_READ;
            end
            if (latch_dx_d) begin
                dx_sh_q <= BYTE_READ;
            end
            if (commit_d) begin
                mouse_status_q <= status_sh_q;
                mouse_dx_q     <= dx_sh_q;
                mouse_dy_q     <= BYTE_READ;
            end
        end
    end

    assign SEND_BYTE      = send_byte_q;
    assign BYTE_TO_SEND   = byte_to_send_q;
    assign READ_ENABLE    = read_enable_q;
    assign MOUSE_STATUS   = mouse_status_q;
    assign MOUSE_DX       = mouse_dx_q;
    assign MOUSE_DY       = mouse_dy_q;
    assign SEND_INTERRUPT = send_interrupt_q;
    assign INIT_DONE      = init_done_q;
    assign STATE          = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm: a vector table walks the init
// handshake and several packets, then hand-written sequences cover the
// watchdogs, a failed self-test and a reset in the middle of a packet.
module tb_mouse_master_sm;

    localparam int TMO = 200;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic       INIT_DONE;
    logic [3:0] STATE;

    int n_cmp = 0;
    int n_bad = 0;

    mouse_master_sm #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SEND_BYTE      (SEND_BYTE),
        .BYTE_TO_SEND   (BYTE_TO_SEND),
        .BYTE_SENT      (BYTE_SENT),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY),
        .MOUSE_STATUS   (MOUSE_STATUS),
        .MOUSE_DX       (MOUSE_DX),
        .MOUSE_DY       (MOUSE_DY),
        .SEND_INTERRUPT (SEND_INTERRUPT),
        .INIT_DONE      (INIT_DONE),
        .STATE          (STATE)
    );

    always #5 CLK = ~CLK;

    // kind: 0 idle cycle, 1 BYTE_SENT pulse, 2 BYTE_READY pulse
    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  data;
        logic [1:0]  err;
        logic [3:0]  st;
        logic        snd;
        logic [7:0]  tx;
        logic        irq;
        logic        done;
        logic        ren;
        logic [23:0] mouse;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] kind, input logic [7:0] data,
                                input logic [1:0] err, input logic [3:0] st,
                                input logic snd, input logic [7:0] tx,
                                input logic irq, input logic done,
                                input logic ren, input logic [23:0] mouse);
        vec_t v;
        v.kind = kind; v.data = data; v.err = err; v.st = st; v.snd = snd;
        v.tx = tx; v.irq = irq; v.done = done; v.ren = ren; v.mouse = mouse;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_sent();
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    task automatic rx(input logic [7:0] b, input logic [1:0] e);
        BYTE_READ = b;
        BYTE_ERROR_CODE = e;
        BYTE_READY = 1'b1;
        tick();
        BYTE_READY = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    function automatic logic [23:0] mouse_now();
        return {MOUSE_STATUS, MOUSE_DX, MOUSE_DY};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int cnt;
        RESET = 1'b1;
        BYTE_SENT = 1'b0;
        BYTE_READ = 8'h00;
        BYTE_ERROR_CODE = 2'b00;
        BYTE_READY = 1'b0;

        //                 kind   data   err   st    snd   tx     irq   done  ren   mouse
        vecs.push_back(mk(2'd0, 8'h00, 2'd0, 4'd1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 24'h000000));
        vecs.push_back(mk(2'd0, 8'h00, 2'd0, 4'd2, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 24'h000000));
        vecs.push_back(mk(2'd2, 8'hFA, 2'd0, 4'd2, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 24'h000000));
        vecs.push_back(mk(2'd1, 8'h00, 2'd0, 4'd3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd1, 8'h00, 2'd0, 4'd3, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'hFA, 2'd0, 4'd4, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'hAA, 2'd0, 4'd5, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'h00, 2'd0, 4'd6, 1'b1, 8'hF4, 1'b0, 1'b0, 1'b0, 24'h000000));
        vecs.push_back(mk(2'd0, 8'h00, 2'd0, 4'd7, 1'b0, 8'hF4, 1'b0, 1'b0, 1'b0, 24'h000000));
        vecs.push_back(mk(2'd1, 8'h00, 2'd0, 4'd8, 1'b0, 8'hF4, 1'b0, 1'b0, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'hFA, 2'd0, 4'd9, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'h08, 2'd0, 4'd10, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'h05, 2'd0, 4'd11, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h000000));
        vecs.push_back(mk(2'd2, 8'hFB, 2'd0, 4'd9, 1'b0, 8'hF4, 1'b1, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h00, 2'd0, 4'd9, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h18, 2'd0, 4'd10, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h01, 2'd1, 4'd9, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h28, 2'd0, 4'd10, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h11, 2'd0, 4'd11, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h22, 2'd2, 4'd9, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h09, 2'd0, 4'd10, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h7F, 2'd0, 4'd11, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0805FB));
        vecs.push_back(mk(2'd2, 8'h80, 2'd0, 4'd9, 1'b0, 8'hF4, 1'b1, 1'b1, 1'b1, 24'h097F80));
        vecs.push_back(mk(2'd2, 8'h0A, 2'd0, 4'd10, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h097F80));
        vecs.push_back(mk(2'd2, 8'h01, 2'd0, 4'd11, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h097F80));
        vecs.push_back(mk(2'd2, 8'h02, 2'd0, 4'd9, 1'b0, 8'hF4, 1'b1, 1'b1, 1'b1, 24'h0A0102));
        vecs.push_back(mk(2'd0, 8'h00, 2'd0, 4'd9, 1'b0, 8'hF4, 1'b0, 1'b1, 1'b1, 24'h0A0102));

        // Reset state
        repeat (3) tick();
        RESET = 1'b0;
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_send", 32'(SEND_BYTE), 32'd0);
        chk("rst_tx", 32'(BYTE_TO_SEND), 32'd0);
        chk("rst_ren", 32'(READ_ENABLE), 32'd0);
        chk("rst_done", 32'(INIT_DONE), 32'd0);
        chk("rst_irq", 32'(SEND_INTERRUPT), 32'd0);
        chk("rst_mouse", 32'(mouse_now()), 32'd0);

        // Table: init handshake and packets
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].kind)
                2'd1:    pulse_sent();
                2'd2:    rx(vecs[i].data, vecs[i].err);
                default: tick();
            endcase
            chk($sformatf("v%0d_state", i), 32'(STATE), 32'(vecs[i].st));
            chk($sformatf("v%0d_send", i), 32'(SEND_BYTE), 32'(vecs[i].snd));
            chk($sformatf("v%0d_tx", i), 32'(BYTE_TO_SEND), 32'(vecs[i].tx));
            chk($sformatf("v%0d_irq", i), 32'(SEND_INTERRUPT), 32'(vecs[i].irq));
            chk($sformatf("v%0d_done", i), 32'(INIT_DONE), 32'(vecs[i].done));
            chk($sformatf("v%0d_ren", i), 32'(READ_ENABLE), 32'(vecs[i].ren));
            chk($sformatf("v%0d_mouse", i), 32'(mouse_now()), 32'(vecs[i].mouse));
        end

        // Streaming watchdog: status byte then silence
        rx(8'h08, 2'b00);
        chk("wd_rx_enter", 32'(STATE), 32'd10);
        cnt = 0;
        while (STATE == 4'd10 && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("wd_rx_cycles", 32'(cnt), 32'(TMO));
        chk("wd_rx_state", 32'(STATE), 32'd9);
        chk("wd_rx_done", 32'(INIT_DONE), 32'd1);
        chk("wd_rx_mouse", 32'(mouse_now()), 32'h0A0102);

        // Reset in the middle of a packet
        rx(8'h08, 2'b00);
        rx(8'h05, 2'b00);
        chk("mid_state", 32'(STATE), 32'd11);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mr_state", 32'(STATE), 32'd0);
        chk("mr_outs", 32'({SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, SEND_INTERRUPT, INIT_DONE}), 32'd0);
        chk("mr_mouse", 32'(mouse_now()), 32'd0);
        tick();
        chk("mr_resend_state", 32'(STATE), 32'd1);
        chk("mr_resend", 32'({SEND_BYTE, BYTE_TO_SEND}), 32'h1FF);

        // Bad self-test result forces a full re-init
        tick();
        pulse_sent();
        rx(8'hFA, 2'b00);
        chk("bst_pre", 32'(STATE), 32'd4);
        rx(8'hFC, 2'b00);
        chk("bst_state", 32'(STATE), 32'd1);
        chk("bst_send", 32'({SEND_BYTE, BYTE_TO_SEND}), 32'h1FF);
        tick();
        chk("bst_send_once", 32'(SEND_BYTE), 32'd0);

        // Handshake watchdog in WAIT_ACK1
        pulse_sent();
        chk("wd_ack_enter", 32'(STATE), 32'd3);
        cnt = 0;
        while (STATE == 4'd3 && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("wd_ack_cycles", 32'(cnt), 32'(TMO));
        chk("wd_ack_state", 32'(STATE), 32'd1);
        chk("wd_ack_send", 32'(SEND_BYTE), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
